cpu_0_div_cell: RTL and testbench

Iterative 32-bit integer divider for the cpu_0 execute/memory pipeline, the inverse companion of the multiplier cell. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring division over 32 cycles. It then returns a 32-bit quotient and a 32-bit remainder with a one-cycle done pulse. Signed or unsigned operation is selected per operation, and the pipeline holds M-stage via `div_busy` while a divide is in flight.

---
 rtl/cpu_0_div_pkg.sv | 10 +
 rtl/cpu_0_div_step.sv | 16 +
 rtl/cpu_0_div_cell.sv | 110 +++++++++++
 tb/tb_cpu_0_div_cell.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cpu_0_div_pkg.sv
// cpu_0_div_pkg: shared types and constants for the iterative divider cell.
package cpu_0_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic n, input logic [DIV_WIDTH-1:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/cpu_0_div_step.sv
// cpu_0_div_step: one combinational radix-2 restoring division step.
module cpu_0_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] sh;
  assign sh = {rem_i, bit_i};
  // The shifted remainder needs W+1 bits; after a successful subtract it fits back in W.
  assign q_o = sh >= {1'b0, dvs_i};
  assign rem_o = q_o ? W'(sh - {1'b0, dvs_i}) : sh[W-1:0];
endmodule

// File: rtl/cpu_0_div_cell.sv
// cpu_0_div_cell: 32-cycle restoring signed/unsigned divider with kill and divide-by-zero fast path.
module cpu_0_div_cell
  import cpu_0_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_div_start,
  input  logic             E_ctrl_div_signed,
  input  logic [WIDTH-1:0] E_src1_div_cell,
  input  logic [WIDTH-1:0] E_src2_div_cell,
  input  logic             M_div_kill,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, remo_q, remo_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
  logic [WIDTH-1:0] step_rem;
  logic step_q;
  logic s1, s2;
  cpu_0_div_step #(.W(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(dvd_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );
  assign s1 = E_ctrl_div_signed & E_src1_div_cell[WIDTH-1];
  assign s2 = E_ctrl_div_signed & E_src2_div_cell[WIDTH-1];
  // dvd_q shifts dividend bits out the top while quotient bits enter at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    quo_d = quo_q;
    remo_d = remo_q;
    done_d = 1'b0;
    if (M_div_kill) state_d = IDLE;
    else case (state_q)
      IDLE: if (E_div_start) begin
        cnt_d = '0;
        dvs_d = cond_neg(s2, E_src2_div_cell);
        if (E_src2_div_cell == '0) begin
          dvd_d = WIDTH'(DIV0_QUOTIENT);
          rem_d = E_src1_div_cell;
          qneg_d = 1'b0;
          rneg_d = 1'b0;
          state_d = FIX;
        end else begin
          dvd_d = cond_neg(s1, E_src1_div_cell);
          rem_d = '0;
          qneg_d = s1 ^ s2;
          rneg_d = s1;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(WIDTH-1) ? FIX : CALC;
      end
      FIX: begin
        quo_d = cond_neg(qneg_q, dvd_q);
        remo_d = cond_neg(rneg_q, rem_q);
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      quo_q <= '0;
      remo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      quo_q <= quo_d;
      remo_q <= remo_d;
      done_q <= done_d;
    end
  end
  assign div_busy = state_q != IDLE;
  assign div_done = done_q;
  assign div_quotient = quo_q;
  assign div_remainder = remo_q;
endmodule

// File: tb/tb_cpu_0_div_cell.sv
// tb_cpu_0_div_cell: directed self-checking bench for the iterative divider.
module tb_cpu_0_div_cell;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0, kill = 1'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic busy, done;
  logic [31:0] quo, rem;
  logic [31:0] last_q, last_r;
  int checks = 0, errors = 0;
  cpu_0_div_cell dut (
    .clk(clk),
    .reset(reset),
    .E_div_start(start),
    .E_ctrl_div_signed(sgn),
    .E_src1_div_cell(src1),
    .E_src2_div_cell(src2),
    .M_div_kill(kill),
    .div_busy(busy),
    .div_done(done),
    .div_quotient(quo),
    .div_remainder(rem)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sgn = s;
    src1 = a;
    src2 = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int elat, input logic restart);
    int n, nb;
    launch(s, a, b);
    n = 0;
    nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      if (restart && n == 5) begin
        @(negedge clk);
        src1 = 32'd1000;
        src2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    check({tag, " latency"}, n + 1, elat);
    check({tag, " busy cycles"}, nb, elat - 1);
    check({tag, " busy in done cycle"}, {31'b0, busy}, 32'd0);
    check({tag, " quotient"}, quo, eq);
    check({tag, " remainder"}, rem, er);
    last_q = eq;
    last_r = er;
    @(posedge clk);
    #1 check({tag, " single done pulse"}, {31'b0, done}, 32'd0);
  endtask
  initial begin
    int seen;
    last_q = '0;
    last_r = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset quotient", quo, 32'd0);
    check("reset remainder", rem, 32'd0);
    do_div("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);
    do_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0);
    do_div("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 1'b0);
    do_div("u big/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 34, 1'b0);
    do_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 1'b0);
    do_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
    do_div("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 2, 1'b0);
    do_div("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 2, 1'b0);
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill busy drop", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    check("kill no done", seen, 0);
    check("kill quotient held", quo, last_q);
    check("kill remainder held", rem, last_r);
    do_div("u 9/4 after kill", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 34, 1'b0);
    do_div("start while busy", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b1);
    launch(1'b1, 32'd77, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset done", {31'b0, done}, 32'd0);
    check("midreset quotient", quo, 32'd0);
    check("midreset remainder", rem, 32'd0);
    @(negedge clk);
    sgn = 1'b0;
    src1 = 32'd20;
    src2 = 32'd3;
    start = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1 begin
      start = 1'b0;
      kill = 1'b0;
    end
    check("start+kill idle busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(posedge clk);
      #1;
    end
    check("start+kill no activity", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
